// File: rtl/uart_prog_loader.sv
// UART programming loader: parses CMD/LEN/data frames from a byte stream
// and emits 32-bit word writes to instruction or data memory.
module uart_prog_loader #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic        upg_clk_i,
  input  logic        upg_rst_n_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        err_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA
  } state_t;

  state_t        r_state;
  logic          r_tgt;
  logic [13:0]   r_wadr;
  logic [15:0]   r_len;
  logic [1:0]    r_bcnt;
  logic [23:0]   r_asm;
  logic [TW-1:0] r_tmo;

  logic [15:0] w_len;
  logic        w_last;
  logic        w_tmo;

  assign w_len  = {rx_data_i, r_len[7:0]};
  assign w_last = ({2'b00, r_wadr} == (r_len - 16'd1));
  assign w_tmo  = (r_state != S_IDLE) && !rx_valid_i
                  && (r_tmo == TMO_MAX);

  always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
    if (!upg_rst_n_i) begin
      r_state    <= S_IDLE;
      r_tgt      <= 1'b0;
      r_wadr     <= '0;
      r_len      <= '0;
      r_bcnt     <= '0;
      r_asm      <= '0;
      r_tmo      <= '0;
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
      upg_done_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      upg_wen_o <= 1'b0;
      if (rx_valid_i || r_state == S_IDLE)
        r_tmo <= '0;
      else
        r_tmo <= r_tmo + TW'(1);

      if (w_tmo) begin
        // Stalled frame: drop any partial word and resync on a CMD
        err_o   <= 1'b1;
        r_state <= S_IDLE;
        r_bcnt  <= '0;
        r_tmo   <= '0;
      end else if (rx_valid_i) begin
        unique case (r_state)
          S_IDLE: begin
            unique case (rx_data_i)
              8'h01, 8'h02: begin
                r_tgt      <= rx_data_i[1];
                r_wadr     <= '0;
                upg_done_o <= 1'b0;
                err_o      <= 1'b0;
                r_state    <= S_LEN_LO;
              end
              8'hFF:   upg_done_o <= 1'b1;
              default: err_o <= 1'b1;
            endcase
          end
          S_LEN_LO: begin
            r_len[7:0] <= rx_data_i;
            r_state    <= S_LEN_HI;
          end
          S_LEN_HI: begin
            r_len <= w_len;
            if (w_len == 16'd0) begin
              r_state <= S_IDLE;
            end else if (w_len > 16'd16384) begin
              err_o   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_bcnt  <= '0;
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            r_asm  <= {rx_data_i, r_asm[23:8]};
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              upg_wen_o <= 1'b1;
              upg_dat_o <= {rx_data_i, r_asm};
              upg_adr_o <= {r_tgt, r_wadr};
              r_wadr    <= r_wadr + 14'd1;
              if (w_last)
                r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: frame-level model checked every cycle
// plus literal expectations on the recorded write pulses.
module tb_uart_prog_loader;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_d = 8'h00;
  logic        rx_v = 1'b0;
  logic        wen;
  logic [14:0] adr;
  logic [31:0] dat;
  logic        done;
  logic        err;

  uart_prog_loader #(.TIMEOUT_CYC(TMO)) dut (
    .upg_clk_i   (clk),
    .upg_rst_n_i (rst_n),
    .rx_data_i   (rx_d),
    .rx_valid_i  (rx_v),
    .upg_wen_o   (wen),
    .upg_adr_o   (adr),
    .upg_dat_o   (dat),
    .upg_done_o  (done),
    .err_o       (err)
  );

  always #50 clk = ~clk;

  int total = 0;
  int bad = 0;

  int          m_phase;
  int          m_len;
  int          m_words;
  int          m_idle;
  logic [7:0]  m_q[$];
  logic        m_tgt;
  logic        m_err;
  logic        m_done;
  logic        e_wen;
  logic [14:0] e_adr;
  logic [31:0] e_dat;

  logic [14:0] log_adr[$];
  logic [31:0] log_dat[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_len   = 0;
    m_words = 0;
    m_idle  = 0;
    m_q.delete();
    m_tgt   = 1'b0;
    m_err   = 1'b0;
    m_done  = 1'b0;
    e_wen   = 1'b0;
    e_adr   = '0;
    e_dat   = '0;
  endtask

  // Frame-level model: phases cmd/len_lo/len_hi/data, bytes gathered in a queue
  task automatic model_step(input logic v, input logic [7:0] d);
    e_wen = 1'b0;
    if (m_phase != 0) begin
      if (v) begin
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == TMO) begin
          m_err = 1'b1;
          m_phase = 0;
          m_q.delete();
        end
      end
    end else begin
      m_idle = 0;
    end
    if (v) begin
      case (m_phase)
        0: begin
          if (d == 8'h01 || d == 8'h02) begin
            m_tgt   = (d == 8'h02);
            m_words = 0;
            m_err   = 1'b0;
            m_done  = 1'b0;
            m_phase = 1;
          end else if (d == 8'hFF) begin
            m_done = 1'b1;
          end else begin
            m_err = 1'b1;
          end
        end
        1: begin
          m_len = int'(d);
          m_phase = 2;
        end
        2: begin
          m_len = m_len + int'(d) * 256;
          if (m_len == 0) begin
            m_phase = 0;
          end else if (m_len > 16384) begin
            m_err = 1'b1;
            m_phase = 0;
          end else begin
            m_phase = 3;
            m_q.delete();
          end
        end
        default: begin
          m_q.push_back(d);
          if (m_q.size() == 4) begin
            e_wen = 1'b1;
            e_adr = 15'(m_words + (m_tgt ? 16384 : 0));
            e_dat = {m_q[3], m_q[2], m_q[1], m_q[0]};
            m_words++;
            m_q.delete();
            if (m_words == m_len) m_phase = 0;
          end
        end
      endcase
    end
  endtask

  task automatic compare();
    chk("wen", 32'(wen), 32'(e_wen));
    chk("adr", 32'(adr), 32'(e_adr));
    chk("dat", dat, e_dat);
    chk("err", 32'(err), 32'(m_err));
    chk("done", 32'(done), 32'(m_done));
    if (wen) begin
      log_adr.push_back(adr);
      log_dat.push_back(dat);
    end
  endtask

  task automatic tick(input logic v, input logic [7:0] d);
    rx_v = v;
    rx_d = d;
    @(posedge clk);
    if (rst_n) model_step(v, d);
    #1;
    compare();
  endtask

  task automatic send(input int n, input logic [127:0] v);
    for (int i = 0; i < n; i++)
      tick(1'b1, v[(n-1-i)*8 +: 8]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      tick(1'b0, 8'h00);
  endtask

  task automatic clr_log();
    log_adr.delete();
    log_dat.delete();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_wen"}, 32'(wen), 0);
    chk({nm, "_adr"}, 32'(adr), 0);
    chk({nm, "_dat"}, dat, 0);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_err"}, 32'(err), 0);
  endtask

  initial begin
    model_reset();
    #10;
    chk_zero("rst");
    repeat (2) @(posedge clk);
    #20 rst_n = 1'b1;

    // Two-word instruction load
    clr_log();
    send(11, 128'h01_02_00_78_56_34_12_EF_BE_AD_DE);
    idle(2);
    chk("s1_cnt", log_adr.size(), 2);
    chk("s1_adr0", 32'(log_adr[0]), 32'h0000);
    chk("s1_dat0", log_dat[0], 32'h12345678);
    chk("s1_adr1", 32'(log_adr[1]), 32'h0001);
    chk("s1_dat1", log_dat[1], 32'hDEADBEEF);

    // Data-memory load then finish
    clr_log();
    send(7, 128'h02_01_00_11_22_33_44);
    send(1, 128'hFF);
    chk("s2_done", 32'(done), 1);
    chk("s2_cnt", log_adr.size(), 1);
    chk("s2_adr", 32'(log_adr[0]), 32'h4000);
    chk("s2_dat", log_dat[0], 32'h44332211);

    // Length corner cases and bad CMD
    clr_log();
    send(3, 128'h01_00_00);
    idle(2);
    chk("s3_len0_err", 32'(err), 0);
    chk("s3_len0_done", 32'(done), 0);
    send(3, 128'h01_01_41);
    idle(1);
    chk("s3_big_err", 32'(err), 1);
    send(3, 128'h01_00_00);
    chk("s3_clr_err", 32'(err), 0);
    send(1, 128'h7A);
    chk("s3_cmd_err", 32'(err), 1);
    chk("s3_cnt", log_adr.size(), 0);

    // Timeout mid-word, then a clean frame
    send(5, 128'h01_01_00_AA_BB);
    idle(TMO - 1);
    chk("s4_pre_err", 32'(err), 0);
    idle(1);
    chk("s4_tmo_err", 32'(err), 1);
    idle(3);
    chk("s4_cnt0", log_adr.size(), 0);
    send(7, 128'h01_01_00_01_02_03_04);
    idle(2);
    chk("s4_cnt", log_adr.size(), 1);
    chk("s4_adr", 32'(log_adr[0]), 0);
    chk("s4_dat", log_dat[0], 32'h04030201);

    // Reset in the middle of a word
    clr_log();
    send(5, 128'h01_01_00_A1_A2);
    #10 rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    model_reset();
    idle(2);
    #20 rst_n = 1'b1;
    send(2, 128'hA3_A4);
    idle(2);
    chk("s5_stale_cnt", log_adr.size(), 0);
    send(7, 128'h01_01_00_C1_C2_C3_C4);
    idle(2);
    chk("s5_cnt", log_adr.size(), 1);
    chk("s5_adr", 32'(log_adr[0]), 0);
    chk("s5_dat", log_dat[0], 32'hC4C3C2C1);

    // Back-to-back bytes, LEN=3
    clr_log();
    send(15, 128'h01_03_00_10_11_12_13_20_21_22_23_30_31_32_33);
    idle(3);
    chk("s6_cnt", log_adr.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("s6_adr", 32'(log_adr[i]), i);
    chk("s6_dat0", log_dat[0], 32'h13121110);
    chk("s6_dat1", log_dat[1], 32'h23222120);
    chk("s6_dat2", log_dat[2], 32'h33323130);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
